// File: rtl/err_eval_pkg.sv
// Shared types and constants for the approximate-circuit error monitor.
package err_eval_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } state_e;

    localparam int unsigned RPT_WORDS   = 4;
    localparam int unsigned RPT_IDX_W   = $clog2(RPT_WORDS);
    localparam int unsigned RPT_SAMPLES = 0;
    localparam int unsigned RPT_ERRORS  = 1;
    localparam int unsigned RPT_SUM     = 2;
    localparam int unsigned RPT_MAX     = 3;

endpackage

// File: rtl/err_distance.sv
// Golden multiplier (input side, feeds S1) and absolute error distance (S1 -> S2).
module err_distance #(
    parameter int unsigned IN_W  = 4,
    parameter int unsigned OUT_W = 4
) (
    input  logic [IN_W-1:0]  pi_i,
    output logic [OUT_W-1:0] exact_o,
    input  logic [OUT_W-1:0] exact_i,
    input  logic [OUT_W-1:0] po_i,
    output logic [OUT_W-1:0] ed_o,
    output logic             err_o
);

    localparam int unsigned A_W = IN_W / 2;
    localparam int unsigned B_W = IN_W - A_W;
    localparam int unsigned M_W = (IN_W > OUT_W) ? IN_W : OUT_W;

    logic [A_W-1:0] op_a;
    logic [B_W-1:0] op_b;
    logic [M_W-1:0] prod;

    // Product is kept at least OUT_W wide so truncation is always a plain slice.
    always_comb begin
        op_a    = pi_i[A_W-1:0];
        op_b    = pi_i[IN_W-1:A_W];
        prod    = M_W'(op_a) * M_W'(op_b);
        exact_o = prod[OUT_W-1:0];
    end

    always_comb begin
        ed_o  = (exact_i >= po_i) ? (exact_i - po_i) : (po_i - exact_i);
        err_o = (exact_i != po_i);
    end

endmodule

// File: rtl/err_accum_monitor.sv
// Streams (vector, approximate output) samples, accumulates error statistics
// against a golden product, and emits them as a 4-word report on request.
module err_accum_monitor
    import err_eval_pkg::*;
#(
    parameter int unsigned IN_W  = 4,
    parameter int unsigned OUT_W = 4,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned ACC_W = 24,
    parameter int unsigned RPT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [IN_W-1:0]  s_pi,
    input  logic [OUT_W-1:0] s_po,
    input  logic             clear,
    input  logic             report_req,
    output logic             r_valid,
    input  logic             r_ready,
    output logic [RPT_W-1:0] r_data,
    output logic             r_last,
    output logic             busy
);

    localparam int unsigned SUM_EXT_W = ACC_W + 1;

    state_e state_q, state_d;

    logic                 clear_eff, accept;
    logic                 s1_v_q, s2_v_q, s2_err_q, err_c;
    logic [OUT_W-1:0]     s1_exact_q, s1_po_q, s2_ed_q, exact_c, ed_c;

    logic [CNT_W-1:0]     samples_q, samples_d, errors_q, errors_d;
    logic [ACC_W-1:0]     sum_q, sum_d;
    logic [OUT_W-1:0]     max_q, max_d;
    logic [SUM_EXT_W-1:0] sum_ext;

    logic                 s_ready_q, s_ready_d, busy_q, busy_d;
    logic                 r_valid_q, r_valid_d, r_last_q, r_last_d, rpt_load;
    logic [RPT_W-1:0]     r_data_q, r_data_d;
    logic [RPT_IDX_W-1:0] rpt_idx_q, rpt_idx_d;

    // clear only acts while samples are being collected; a same-cycle sample is dropped.
    assign clear_eff = clear && ((state_q == ST_IDLE) || (state_q == ST_ACCUM));
    assign accept    = s_valid && s_ready_q && !clear_eff;

    err_distance #(.IN_W(IN_W), .OUT_W(OUT_W)) u_dist (
        .pi_i    (s_pi),
        .exact_o (exact_c),
        .exact_i (s1_exact_q),
        .po_i    (s1_po_q),
        .ed_o    (ed_c),
        .err_o   (err_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q     <= 1'b0;
            s1_exact_q <= '0;
            s1_po_q    <= '0;
            s2_v_q     <= 1'b0;
            s2_ed_q    <= '0;
            s2_err_q   <= 1'b0;
        end else begin
            s1_v_q     <= accept;
            s1_exact_q <= exact_c;
            s1_po_q    <= s_po;
            s2_v_q     <= s1_v_q && !clear_eff;
            s2_ed_q    <= ed_c;
            s2_err_q   <= err_c;
        end
    end

    // Accumulate stage: saturating counters, frozen entirely once samples is full.
    always_comb begin
        samples_d = samples_q;
        errors_d  = errors_q;
        sum_d     = sum_q;
        max_d     = max_q;
        sum_ext   = SUM_EXT_W'(sum_q) + SUM_EXT_W'(s2_ed_q);
        if (clear_eff) begin
            samples_d = '0;
            errors_d  = '0;
            sum_d     = '0;
            max_d     = '0;
        end else if (s2_v_q && (samples_q != {CNT_W{1'b1}})) begin
            samples_d = samples_q + CNT_W'(1);
            if (s2_err_q && (errors_q != {CNT_W{1'b1}})) begin
                errors_d = errors_q + CNT_W'(1);
            end
            sum_d = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
            max_d = (s2_ed_q > max_q) ? s2_ed_q : max_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            samples_q <= '0;
            errors_q  <= '0;
            sum_q     <= '0;
            max_q     <= '0;
        end else begin
            samples_q <= samples_d;
            errors_q  <= errors_d;
            sum_q     <= sum_d;
            max_q     <= max_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (report_req) begin
                    state_d = ST_DRAIN;
                end else if (accept) begin
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (report_req) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!s1_v_q && !s2_v_q) begin
                    state_d = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (r_valid_q && r_ready && (rpt_idx_q == RPT_IDX_W'(RPT_MAX))) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; a report word is loaded on REPORT entry and after each transfer.
    always_comb begin
        s_ready_d = (state_d == ST_IDLE) || (state_d == ST_ACCUM);
        busy_d    = (state_d == ST_DRAIN) || (state_d == ST_REPORT);
        r_valid_d = r_valid_q;
        r_data_d  = r_data_q;
        r_last_d  = r_last_q;
        rpt_idx_d = rpt_idx_q;
        rpt_load  = 1'b0;
        if ((state_q == ST_DRAIN) && (state_d == ST_REPORT)) begin
            rpt_load  = 1'b1;
            rpt_idx_d = '0;
        end else if ((state_q == ST_REPORT) && r_valid_q && r_ready) begin
            if (rpt_idx_q == RPT_IDX_W'(RPT_MAX)) begin
                r_valid_d = 1'b0;
                r_last_d  = 1'b0;
                r_data_d  = '0;
            end else begin
                rpt_load  = 1'b1;
                rpt_idx_d = rpt_idx_q + RPT_IDX_W'(1);
            end
        end
        if (rpt_load) begin
            r_valid_d = 1'b1;
            r_last_d  = (rpt_idx_d == RPT_IDX_W'(RPT_MAX));
            case (rpt_idx_d)
                RPT_IDX_W'(RPT_SAMPLES): r_data_d = RPT_W'(samples_q);
                RPT_IDX_W'(RPT_ERRORS):  r_data_d = RPT_W'(errors_q);
                RPT_IDX_W'(RPT_SUM):     r_data_d = RPT_W'(sum_q);
                default:                 r_data_d = RPT_W'(max_q);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            r_last_q  <= 1'b0;
            rpt_idx_q <= '0;
        end else begin
            s_ready_q <= s_ready_d;
            busy_q    <= busy_d;
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
            r_last_q  <= r_last_d;
            rpt_idx_q <= rpt_idx_d;
        end
    end

    assign s_ready = s_ready_q;
    assign busy    = busy_q;
    assign r_valid = r_valid_q;
    assign r_data  = r_data_q;
    assign r_last  = r_last_q;

endmodule

// File: tb/tb_err_accum_monitor.sv
// Randomized and directed bench for err_accum_monitor; a full-width instance and a
// narrow-counter instance share stimulus so saturation is reachable in few cycles.
module tb_err_accum_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic [3:0]  s_pi = '0;
    logic [3:0]  s_po = '0;
    logic        clear = 1'b0;
    logic        report_req = 1'b0;
    logic        r_ready = 1'b1;

    logic        s_ready_m, r_valid_m, r_last_m, busy_m;
    logic [31:0] r_data_m;
    logic        s_ready_s, r_valid_s, r_last_s, busy_s;
    logic [31:0] r_data_s;

    always #5 clk = ~clk;

    err_accum_monitor #(.IN_W(4), .OUT_W(4), .CNT_W(16), .ACC_W(24), .RPT_W(32)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_m), .s_pi(s_pi), .s_po(s_po),
        .clear(clear), .report_req(report_req), .r_valid(r_valid_m), .r_ready(r_ready),
        .r_data(r_data_m), .r_last(r_last_m), .busy(busy_m)
    );

    err_accum_monitor #(.IN_W(4), .OUT_W(4), .CNT_W(4), .ACC_W(6), .RPT_W(32)) dut_sat (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_s), .s_pi(s_pi), .s_po(s_po),
        .clear(clear), .report_req(report_req), .r_valid(r_valid_s), .r_ready(r_ready),
        .r_data(r_data_s), .r_last(r_last_s), .busy(busy_s)
    );

    int n_checks = 0;
    int n_errs   = 0;

    // Reference statistics per instance: [0] full width, [1] narrow
    int m_samp[2];
    int m_errs[2];
    int m_sum[2];
    int m_max[2];
    int cnt_max[2] = '{65535, 15};
    int acc_max[2] = '{16777215, 63};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int exact_of(input int pi);
        return ((pi % 4) * (pi / 4)) % 16;
    endfunction

    function automatic void mdl_clear();
        for (int k = 0; k < 2; k++) begin
            m_samp[k] = 0;
            m_errs[k] = 0;
            m_sum[k]  = 0;
            m_max[k]  = 0;
        end
    endfunction

    function automatic void mdl_add(input int pi, input int po);
        int ex;
        int ed;
        ex = exact_of(pi);
        ed = (ex > po) ? ex - po : po - ex;
        for (int k = 0; k < 2; k++) begin
            if (m_samp[k] < cnt_max[k]) begin
                m_samp[k]++;
                if (ed != 0 && m_errs[k] < cnt_max[k]) m_errs[k]++;
                m_sum[k] = (m_sum[k] + ed > acc_max[k]) ? acc_max[k] : m_sum[k] + ed;
                if (ed > m_max[k]) m_max[k] = ed;
            end
        end
    endfunction

    // One cycle of sample (plus optional clear/report_req); entered and left at a negedge.
    task automatic send(input int pi, input int po, input bit clr, input bit req);
        s_valid = 1'b1;
        s_pi = 4'(pi);
        s_po = 4'(po);
        clear = clr;
        report_req = req;
        @(posedge clk);
        if (clr) mdl_clear();
        else mdl_add(pi, po);
        @(negedge clk);
        s_valid = 1'b0;
        clear = 1'b0;
        report_req = 1'b0;
    endtask

    task automatic pulse(input bit clr, input bit req);
        clear = clr;
        report_req = req;
        @(posedge clk);
        if (clr) mdl_clear();
        @(negedge clk);
        clear = 1'b0;
        report_req = 1'b0;
    endtask

    // Collects the 4 report words from both instances; stall_word >= 4 means no backpressure.
    task automatic get_report(input string tag, input int stall_word, input int stall_cyc);
        int exp_m[4];
        int exp_s[4];
        bit got_it;
        exp_m = '{m_samp[0], m_errs[0], m_sum[0], m_max[0]};
        exp_s = '{m_samp[1], m_errs[1], m_sum[1], m_max[1]};
        got_it = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (r_valid_m) begin
                got_it = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq({tag, "_start"}, 32'(got_it), 1);
        if (!got_it) return;
        for (int w = 0; w < 4; w++) begin
            check_eq($sformatf("%s_valid%0d", tag, w), 32'(r_valid_m), 1);
            check_eq($sformatf("%s_word%0d", tag, w), r_data_m, 32'(exp_m[w]));
            check_eq($sformatf("%s_sat_word%0d", tag, w), r_data_s, 32'(exp_s[w]));
            check_eq($sformatf("%s_last%0d", tag, w), 32'(r_last_m), (w == 3) ? 1 : 0);
            check_eq($sformatf("%s_sat_last%0d", tag, w), 32'(r_last_s), (w == 3) ? 1 : 0);
            if (w == stall_word) begin
                r_ready = 1'b0;
                for (int c = 0; c < stall_cyc; c++) begin
                    @(negedge clk);
                    check_eq($sformatf("%s_hold%0d", tag, c), r_data_m, 32'(exp_m[w]));
                    check_eq($sformatf("%s_holdv%0d", tag, c), 32'(r_valid_m & r_valid_s), 1);
                end
                r_ready = 1'b1;
            end
            @(negedge clk);
        end
        check_eq({tag, "_done_valid"}, 32'(r_valid_m | r_valid_s), 0);
        check_eq({tag, "_done_busy"}, 32'(busy_m | busy_s), 0);
        check_eq({tag, "_done_ready"}, 32'(s_ready_m), 1);
    endtask

    initial begin
        int r;
        int pi;
        int po;
        bit seen;
        mdl_clear();

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_s_ready", 32'(s_ready_m | s_ready_s), 0);
        check_eq("rst_r_valid", 32'(r_valid_m), 0);
        check_eq("rst_r_data", r_data_m, 0);
        check_eq("rst_r_last", 32'(r_last_m), 0);
        check_eq("rst_busy", 32'(busy_m), 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_ready_rise", 32'(s_ready_m), 1);

        send(4'b1011, 4'b0110, 1'b0, 1'b0);
        pulse(1'b0, 1'b1);
        get_report("exact", 4, 0);

        pulse(1'b1, 1'b0);
        send(4'b1011, 4'b0100, 1'b0, 1'b0);
        send(4'b1110, 4'b1001, 1'b0, 1'b0);
        pulse(1'b0, 1'b1);
        get_report("errcase", 4, 0);

        pulse(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) send(4'b1111, 0, 1'b0, (i == 7));
        check_eq("b2b_drain_ready", 32'(s_ready_m), 0);
        check_eq("b2b_drain_busy", 32'(busy_m), 1);
        get_report("b2b", 2, 5);

        send(4'b1111, 4'b0011, 1'b0, 1'b0);
        send(4'b1111, 4'b0000, 1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        get_report("clr_coinc", 4, 0);

        send(4'b1001, 4'b0001, 1'b0, 1'b0);
        pulse(1'b1, 1'b1);
        get_report("clr_req", 4, 0);

        pulse(1'b1, 1'b0);
        for (int i = 0; i < 14; i++) send(4'b0101, 0, 1'b0, 1'b0);
        send(4'b1011, 4'b0100, 1'b0, 1'b0);
        send(4'b1111, 0, 1'b0, 1'b0);
        send(4'b1111, 0, 1'b0, 1'b0);
        pulse(1'b0, 1'b1);
        get_report("sat", 4, 0);

        for (int it = 0; it < 400; it++) begin
            r  = int'($urandom_range(0, 99));
            pi = int'($urandom_range(0, 15));
            po = ($urandom_range(0, 2) == 0) ? exact_of(pi) : int'($urandom_range(0, 15));
            if (r < 70) begin
                send(pi, po, 1'b0, 1'b0);
            end else if (r < 80) begin
                @(negedge clk);
            end else if (r < 83) begin
                pulse(1'b1, 1'b0);
            end else if (r < 86) begin
                send(pi, po, 1'b1, 1'b0);
            end else if (r < 93) begin
                pulse(1'b0, 1'b1);
                get_report("rnd", int'($urandom_range(0, 4)), int'($urandom_range(1, 3)));
            end else begin
                send(pi, po, 1'b0, 1'b1);
                get_report("rnd_tail", int'($urandom_range(0, 4)), int'($urandom_range(1, 3)));
            end
        end
        pulse(1'b0, 1'b1);
        get_report("final", 4, 0);

        send(4'b0111, 4'b0010, 1'b0, 1'b0);
        r_ready = 1'b0;
        pulse(1'b0, 1'b1);
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (r_valid_m) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq("midrst_in_report", 32'(seen), 1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_s_ready", 32'(s_ready_m), 0);
        check_eq("midrst_r_valid", 32'(r_valid_m | r_valid_s), 0);
        check_eq("midrst_r_data", r_data_m, 0);
        check_eq("midrst_r_last", 32'(r_last_m), 0);
        check_eq("midrst_busy", 32'(busy_m), 0);
        rst = 1'b0;
        r_ready = 1'b1;
        mdl_clear();
        @(negedge clk);
        check_eq("midrst_ready_rise", 32'(s_ready_m), 1);
        pulse(1'b0, 1'b1);
        get_report("post_rst", 4, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
